// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr: N-to-1 data mux with per-channel valid/ready and a registered output.
// MODE 0 rotates a fixed TDM slot pointer every accepted cycle; an idle slot
// becomes a bubble. MODE 1 is a work-conserving round-robin that starts its
// search at the pointer.
// Compile-time option: define MUXNX1_BACKPRESSURE_EN to let i_out_ready stall
// the output register. Without it, i_out_ready is ignored and the output
// register accepts every cycle.
module mux_nx1_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      i_gclk,
  input  logic                      i_grst_n,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  input  logic [CHANNELS-1:0]       i_valid,
  output logic [CHANNELS-1:0]       o_ready,
  input  logic                      i_out_ready,
  output logic [WIDTH-1:0]          o_data,
  output logic                      o_valid,
  output logic [CW-1:0]             o_chan
);

  logic [CW-1:0]    r_ptr;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [CW-1:0]    r_chan;

  logic             w_accept;
  logic             w_gnt_vld;
  logic [CW-1:0]    w_gnt_idx;
  logic [CW-1:0]    w_ptr_nxt;
  logic [WIDTH-1:0] w_sel_data;

  // Explicit wrap so non-power-of-two channel counts never overflow into
  // unused pointer codes.
  function automatic logic [CW-1:0] inc_wrap(input logic [CW-1:0] x);
    return (x == CW'(CHANNELS - 1)) ? '0 : x + 1'b1;
  endfunction

`ifdef MUXNX1_BACKPRESSURE_EN
  // Output register loads when empty or when its word is consumed in this cycle.
  assign w_accept = !r_valid || i_out_ready;
`else
  logic w_unused_out_ready;
  assign w_unused_out_ready = i_out_ready;
  assign w_accept = 1'b1;
`endif

  // Grant selection: fixed slot (MODE 0), or the first valid channel at or after ptr (MODE 1).
  always_comb begin
    logic [CW:0] v_idx;
    w_gnt_vld = 1'b0;
    w_gnt_idx = r_ptr;
    v_idx     = '0;
    if (MODE == 0) begin
      w_gnt_vld = i_valid[r_ptr];
    end else begin
      // Walk from the farthest offset down to 0 so the nearest valid channel wins.
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        v_idx = {1'b0, r_ptr} + (CW+1)'(k);
        if (v_idx >= (CW+1)'(CHANNELS)) v_idx = v_idx - (CW+1)'(CHANNELS);
        if (i_valid[v_idx[CW-1:0]]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = v_idx[CW-1:0];
        end
      end
    end
  end

  assign w_sel_data = i_data[w_gnt_idx*WIDTH +: WIDTH];

  // Pointer advance: every accepted slot in TDM, past the winner in round-robin.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (MODE == 0)      w_ptr_nxt = inc_wrap(r_ptr);
    else if (w_gnt_vld) w_ptr_nxt = inc_wrap(w_gnt_idx);
  end

  // One-hot ready toward the granted channel; forced low while in reset.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_rdy
    assign o_ready[i] = w_accept && w_gnt_vld && (w_gnt_idx == CW'(i)) && i_grst_n;
  end

  // Output stage and pointer; a bubble clears valid but keeps the last data/chan.
  always_ff @(posedge i_gclk or negedge i_grst_n) begin
    if (!i_grst_n) begin
      r_ptr   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_chan  <= '0;
    end else if (w_accept) begin
      r_valid <= w_gnt_vld;
      r_ptr   <= w_ptr_nxt;
      if (w_gnt_vld) begin
        r_data <= w_sel_data;
        r_chan <= w_gnt_idx;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_chan  = r_chan;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed bench for mux_nx1_rr: three instances share clock/reset
// (A: MODE 0 / 4 ch, B: MODE 1 / 4 ch, C: MODE 1 / 3 ch).
module tb_mux_nx1_rr;

  logic gclk = 1'b0;
  logic grst_n;
  logic oready;
  always #5 gclk = ~gclk;

  logic [31:0] a_data, b_data;
  logic [23:0] c_data;
  logic [3:0]  a_vld, b_vld, a_rdy, b_rdy;
  logic [2:0]  c_vld, c_rdy;
  logic [7:0]  a_q, b_q, c_q;
  logic        a_v, b_v, c_v;
  logic [1:0]  a_ch, b_ch, c_ch;

  mux_nx1_rr #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u_a (
    .i_gclk(gclk), .i_grst_n(grst_n), .i_data(a_data), .i_valid(a_vld), .o_ready(a_rdy),
    .i_out_ready(oready), .o_data(a_q), .o_valid(a_v), .o_chan(a_ch));
  mux_nx1_rr #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u_b (
    .i_gclk(gclk), .i_grst_n(grst_n), .i_data(b_data), .i_valid(b_vld), .o_ready(b_rdy),
    .i_out_ready(oready), .o_data(b_q), .o_valid(b_v), .o_chan(b_ch));
  mux_nx1_rr #(.WIDTH(8), .CHANNELS(3), .MODE(1)) u_c (
    .i_gclk(gclk), .i_grst_n(grst_n), .i_data(c_data), .i_valid(c_vld), .o_ready(c_rdy),
    .i_out_ready(oready), .o_data(c_q), .o_valid(c_v), .o_chan(c_ch));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  // Drive out_ready: free-running random when it is ignored, held high otherwise.
  task automatic drive_oready();
`ifdef MUXNX1_BACKPRESSURE_EN
    oready = 1'b1;
`else
    oready = 1'($urandom_range(0, 1));
`endif
  endtask

  // Expected per edge E1..E10 (hand-derived)
  logic [7:0] ea_q  [10] = '{8'hA0, 8'hA0, 8'hA2, 8'hA2, 8'hA0, 8'hA0, 8'hA2, 8'hA2, 8'hA0, 8'hA0};
  logic       ea_v  [10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
  logic [3:0] ea_r  [10] = '{4'b0000, 4'b0100, 4'b0000, 4'b0001, 4'b0000,
                             4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0100};
  logic [1:0] eb_ch [10] = '{0, 1, 2, 3, 0, 2, 3, 0, 2, 3};
  logic [1:0] ec_ch [10] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0};

  initial begin
    grst_n = 1'b0;
    oready = 1'b1;
    a_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    b_data = {8'h13, 8'h12, 8'h11, 8'h10};
    c_data = {8'h22, 8'h21, 8'h20};
    a_vld  = 4'hF;
    b_vld  = 4'hF;
    c_vld  = 3'h7;

    // Reset held with every input valid
    #2;
    chk("rst_a_valid", a_v, 0);
    chk("rst_a_data",  a_q, 0);
    chk("rst_a_chan",  a_ch, 0);
    chk("rst_a_ready", a_rdy, 0);
    chk("rst_b_ready", b_rdy, 0);
    chk("rst_c_ready", c_rdy, 0);
    tick();
    tick();
    chk("rst_hold_b_valid", b_v, 0);
    chk("rst_hold_b_data",  b_q, 0);
    chk("rst_hold_b_ready", b_rdy, 0);

    // Release away from the clock edge
    a_vld  = 4'b0101;
    grst_n = 1'b1;
    #1;
    chk("post_rst_a_ready", a_rdy, 4'b0001);
    chk("post_rst_b_ready", b_rdy, 4'b0001);
    chk("post_rst_c_ready", c_rdy, 3'b001);

    for (int k = 0; k < 10; k++) begin
      drive_oready();
      tick();
      chk($sformatf("a_valid_e%0d", k+1), a_v, ea_v[k]);
      chk($sformatf("a_data_e%0d",  k+1), a_q, ea_q[k]);
      chk($sformatf("a_ready_e%0d", k+1), a_rdy, ea_r[k]);
      chk($sformatf("b_chan_e%0d",  k+1), b_ch, eb_ch[k]);
      chk($sformatf("b_data_e%0d",  k+1), b_q, 8'h10 + 8'(eb_ch[k]));
      chk($sformatf("b_valid_e%0d", k+1), b_v, 1);
      chk($sformatf("c_chan_e%0d",  k+1), c_ch, ec_ch[k]);
      chk($sformatf("c_data_e%0d",  k+1), c_q, 8'h20 + 8'(ec_ch[k]));
      if (k == 3) begin
        b_vld = 4'b1101;
        #1;
        chk("b_ready_drop1_ptr0", b_rdy, 4'b0001);
      end
      if (k == 4) chk("b_ready_skip1", b_rdy, 4'b0100);
    end

    // Only channel 3 valid with ptr = 1: granted next edge, ptr wraps to 0
    b_vld = 4'b0001;
    drive_oready();
    tick();
    chk("b_e11_chan", b_ch, 0);
    b_vld = 4'b1000;
    #1;
    chk("b_ready_only3", b_rdy, 4'b1000);
    drive_oready();
    tick();
    chk("b_e12_chan", b_ch, 3);
    chk("b_e12_data", b_q, 8'h13);
    b_vld = 4'b0000;
    #1;
    chk("b_ready_none", b_rdy, 4'b0000);
    drive_oready();
    tick();
    chk("b_e13_valid", b_v, 0);
    chk("b_e13_data_hold", b_q, 8'h13);
    chk("b_e13_chan_hold", b_ch, 3);

    // Reset asserted mid-cycle: outputs clear without a clock edge
    b_vld = 4'hF;
    #3;
    grst_n = 1'b0;
    #1;
    chk("midrst_a_valid", a_v, 0);
    chk("midrst_a_data",  a_q, 0);
    chk("midrst_c_chan",  c_ch, 0);
    chk("midrst_b_ready", b_rdy, 0);
    @(posedge gclk);
    #1;
    grst_n = 1'b1;
    #1;
    chk("restart_a_ready", a_rdy, 4'b0001);
    chk("restart_b_ready", b_rdy, 4'b0001);
    oready = 1'b1;
    tick();
    chk("restart_b_chan",  b_ch, 0);
    chk("restart_b_data",  b_q, 8'h10);
    chk("restart_a_data",  a_q, 8'hA0);
    chk("restart_a_valid", a_v, 1);

`ifdef MUXNX1_BACKPRESSURE_EN
    // Stall with word 0x10 pending: output and ready frozen
    oready = 1'b0;
    #1;
    chk("bp_ready_stall", b_rdy, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp_hold_data_%0d", k), b_q, 8'h10);
      chk($sformatf("bp_hold_chan_%0d", k), b_ch, 0);
      chk($sformatf("bp_hold_ready_%0d", k), b_rdy, 0);
    end
    oready = 1'b1;
    #1;
    chk("bp_release_ready", b_rdy, 4'b0010);
    tick();
    chk("bp_next_chan", b_ch, 1);
    chk("bp_next_data", b_q, 8'h11);
    tick();
    chk("bp_next2_chan", b_ch, 2);
`else
    // out_ready low must not stall anything in this build
    oready = 1'b0;
    #1;
    chk("nobp_ready", b_rdy, 4'b0010);
    tick();
    chk("nobp_chan", b_ch, 1);
    chk("nobp_data", b_q, 8'h11);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
